udp_tx_arbiter: RTL and testbench
=================================

// Module: udp_tx_arbiter
// PURPOSE
//  Round-robin, packet-granular arbiter that shares one packet_gen UDP TX path between
//  N_SRC AXI-stream producers. Picks one source, then forwards its whole packet (first
//  beat through tlast) to the packet_gen s_axis port with tuser (beat count) held stable.
//  Sits directly upstream of packet_gen.
// PARAMETERS
//  N_SRC       4   number of requesting sources (2..8)
//  WORD_BYTES  1   bytes per beat; must match packet_gen WORD_BYTES
//  LEN_W       12  tuser width (beats per packet)
// PORTS
//  clk_i            in   1               single clock
//  rst_i            in   1               reset: synchronous, active-high
//  s_axis_tdata_i   in   N_SRC*WB*8      source i data in slice [i*WB*8 +: WB*8]
//  s_axis_tvalid_i  in   N_SRC           per-source valid
//  s_axis_tlast_i   in   N_SRC           per-source last beat
//  s_axis_tuser_i   in   N_SRC*LEN_W     per-source packet length in beats
//  s_axis_tready_o  out  N_SRC           per-source ready
//  m_axis_tdata_o   out  WB*8            to packet_gen s_axis_tdata_i
//  m_axis_tvalid_o  out  1               to packet_gen s_axis_tvalid_i
//  m_axis_tlast_o   out  1               to packet_gen s_axis_tlast_i
//  m_axis_tuser_o   out  LEN_W           to packet_gen s_axis_tuser_i
//  m_axis_tready_i  in   1               from packet_gen s_axis_tready_o
//  grant_o          out  N_SRC           one-hot current owner; 0 when idle
//  len_err_o        out  1               1-cycle pulse: tlast beat count != latched tuser
// BEHAVIOUR
//  - Reset: FSM=IDLE, grant_o=0, s_axis_tready_o=0, m_axis_tvalid_o=0, m_axis_tlast_o=0,
//    m_axis_tuser_o=0, len_err_o=0, last-grant pointer=N_SRC-1 (so source 0 wins first).
//  - FSM states IDLE, XFER.
//  - IDLE: all tready_o=0, m_tvalid=0. When any s_tvalid[i]=1, pick first asserted index
//    scanning ptr+1, ptr+2, ... (mod N_SRC). Register grant_o, latch m_axis_tuser_o from that
//    source's tuser, clear beat counter, go XFER. Request-to-grant latency: 1 cycle.
//  - XFER: combinational mux of granted source g: m_tdata/tvalid/tlast = source g;
//    s_tready[g] = m_tready_i; all other s_tready = 0. m_axis_tuser_o held at latched value
//    for the whole packet (packet_gen sizes FIFO space from it).
//  - Beat accepted when m_tvalid && m_tready_i; beat counter (LEN_W+1 bits, saturating)
//    increments per accepted beat.
//  - Accepted beat with tlast: ptr<=g, grant_o<=0, go IDLE next cycle; len_err_o pulses the
//    following cycle if counter+1 != latched tuser (includes tuser=0). Packet still forwarded.
//  - One-cycle IDLE bubble between packets is required; back-to-back packets from same
//    source re-arbitrate (others get their turn).
//  - Source dropping tvalid mid-packet: grant held, no timeout; m_tvalid follows source.
//  - packet_gen may hold tready low at first beat (FIFO full): grant held until accepted.
//  - Requests arriving during XFER are ignored until IDLE; no source starves (RR fairness:
//    any continuously-valid source granted within N_SRC packets).
//  - Reset mid-packet: abort immediately to reset values; partial packet is not completed.
// CONFIGURATION
//  TX_ARB_STATS_EN defined: adds output pkt_count_o [N_SRC*16], per-source count of
//    packets completed (tlast accepted), wraps 16'hFFFF->0, cleared by rst_i; also adds
//    err_count_o [16] counting len_err_o pulses, wrapping.
//  Not defined: neither port exists; no counter logic.
// TESTING
//  - Reset then src0 tvalid, tuser=4, 4 beats A0..A3, m_tready=1 -> grant_o=0001 one cycle
//    after tvalid, m_tdata A0..A3, m_tuser=4 throughout, tlast on A3, len_err_o=0.
//  - All 4 sources valid continuously, 2-beat packets -> grant order 0,1,2,3,0 with one
//    IDLE cycle between packets.
//  - src2 granted, m_tready held 0 for 10 cycles at first beat -> grant_o stays 0100,
//    s_tready[2]=0, no beat lost; transfer resumes when m_tready=1.
//  - src1 tuser=3 but tlast on beat 5 -> all 5 beats forwarded, len_err_o=1 for one cycle
//    after tlast, ptr=1.
//  - rst_i asserted on beat 2 of 6 -> next cycle all outputs at reset values; after release
//    src0 wins first arbitration.
//  - TX_ARB_STATS_EN: 3 packets from src3 -> pkt_count_o[3]=3, others 0; 65537 packets
//    from src0 -> pkt_count_o[0]=1.

Source files
------------

// File: rtl/udp_tx_arbiter.sv
// Packet-granular round-robin arbiter that feeds one packet_gen TX path from N_SRC AXI-stream sources.
// Defining TX_ARB_STATS_EN adds per-source packet counters and a length-error counter.
module udp_tx_arbiter #(
    parameter int unsigned N_SRC      = 4,
    parameter int unsigned WORD_BYTES = 1,
    parameter int unsigned LEN_W      = 12
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [N_SRC*WORD_BYTES*8-1:0] s_axis_tdata_i,
    input  logic [N_SRC-1:0]              s_axis_tvalid_i,
    input  logic [N_SRC-1:0]              s_axis_tlast_i,
    input  logic [N_SRC*LEN_W-1:0]        s_axis_tuser_i,
    output logic [N_SRC-1:0]              s_axis_tready_o,
    output logic [WORD_BYTES*8-1:0]       m_axis_tdata_o,
    output logic                          m_axis_tvalid_o,
    output logic                          m_axis_tlast_o,
    output logic [LEN_W-1:0]              m_axis_tuser_o,
    input  logic                          m_axis_tready_i,
    output logic [N_SRC-1:0]              grant_o,
    output logic                          len_err_o
`ifdef TX_ARB_STATS_EN
    ,
    output logic [N_SRC*16-1:0]           pkt_count_o,
    output logic [15:0]                   err_count_o
`endif
);

    localparam int unsigned DW    = WORD_BYTES * 8;
    localparam int unsigned PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [0:0] {StIdle, StXfer} state_e;

    state_e           state_q;
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] gidx_q;
    logic [LEN_W:0]   cnt_q;
    logic [LEN_W:0]   cnt_inc;
    logic             pick_valid;
    logic [PTR_W-1:0] pick_idx;
    logic             accept;

    // Scan ptr+1, ptr+2, ... so the most recent owner is considered last.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int unsigned k = 1; k <= N_SRC; k++) begin
            int unsigned      cand;
            logic [PTR_W-1:0] cand_idx;
            cand = 32'(ptr_q) + k;
            if (cand >= N_SRC) begin
                cand = cand - N_SRC;
            end
            cand_idx = PTR_W'(cand);
            if (!pick_valid && s_axis_tvalid_i[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        m_axis_tdata_o  = s_axis_tdata_i[32'(gidx_q)*DW +: DW];
        m_axis_tvalid_o = 1'b0;
        m_axis_tlast_o  = 1'b0;
        s_axis_tready_o = '0;
        if (state_q == StXfer) begin
            m_axis_tvalid_o         = s_axis_tvalid_i[gidx_q];
            m_axis_tlast_o          = s_axis_tlast_i[gidx_q];
            s_axis_tready_o[gidx_q] = m_axis_tready_i;
        end
    end

    assign accept  = m_axis_tvalid_o && m_axis_tready_i;
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            ptr_q          <= PTR_W'(N_SRC - 1);
            gidx_q         <= '0;
            grant_o        <= '0;
            m_axis_tuser_o <= '0;
            cnt_q          <= '0;
            len_err_o      <= 1'b0;
        end else begin
            len_err_o <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        grant_o        <= N_SRC'(1) << pick_idx;
                        gidx_q         <= pick_idx;
                        m_axis_tuser_o <= s_axis_tuser_i[32'(pick_idx)*LEN_W +: LEN_W];
                        cnt_q          <= '0;
                        state_q        <= StXfer;
                    end
                end
                StXfer: begin
                    if (accept) begin
                        cnt_q <= cnt_inc;
                        if (m_axis_tlast_o) begin
                            ptr_q     <= gidx_q;
                            grant_o   <= '0;
                            len_err_o <= (cnt_inc != {1'b0, m_axis_tuser_o});
                            state_q   <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef TX_ARB_STATS_EN
    logic [15:0] pkt_cnt_q [N_SRC];
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < N_SRC; i++) begin
                pkt_cnt_q[i] <= '0;
            end
            err_cnt_q <= '0;
        end else begin
            if (state_q == StXfer && accept && m_axis_tlast_o) begin
                pkt_cnt_q[gidx_q] <= pkt_cnt_q[gidx_q] + 16'd1;
            end
            if (len_err_o) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        pkt_count_o = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            pkt_count_o[i*16 +: 16] = pkt_cnt_q[i];
        end
    end

    assign err_count_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed self-checking bench for udp_tx_arbiter (N_SRC=4, 1-byte beats, 12-bit tuser).
module tb_udp_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_tdata;
    logic [3:0]  s_tvalid;
    logic [3:0]  s_tlast;
    logic [47:0] s_tuser;
    logic [3:0]  s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic [11:0] m_tuser;
    logic        m_tready;
    logic [3:0]  grant;
    logic        len_err;
`ifdef TX_ARB_STATS_EN
    logic [63:0] pkt_count;
    logic [15:0] err_count;
`endif

    logic [7:0]  d [4];
    logic [11:0] u [4];
    logic [3:0]  v;
    logic [3:0]  l;
    logic [3:0]  bt;
    logic        auto_en;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    udp_tx_arbiter #(
        .N_SRC      (4),
        .WORD_BYTES (1),
        .LEN_W      (12)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .s_axis_tdata_i  (s_tdata),
        .s_axis_tvalid_i (s_tvalid),
        .s_axis_tlast_i  (s_tlast),
        .s_axis_tuser_i  (s_tuser),
        .s_axis_tready_o (s_tready),
        .m_axis_tdata_o  (m_tdata),
        .m_axis_tvalid_o (m_tvalid),
        .m_axis_tlast_o  (m_tlast),
        .m_axis_tuser_o  (m_tuser),
        .m_axis_tready_i (m_tready),
        .grant_o         (grant),
        .len_err_o       (len_err)
`ifdef TX_ARB_STATS_EN
        ,
        .pkt_count_o     (pkt_count),
        .err_count_o     (err_count)
`endif
    );

    // In auto mode every source streams endless 2-beat packets: data {src, beat}, tlast on beat 1.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            s_tdata[i*8 +: 8]   = auto_en ? {4'(i), 3'b000, bt[i]} : d[i];
            s_tlast[i]          = auto_en ? bt[i] : l[i];
            s_tuser[i*12 +: 12] = u[i];
        end
        s_tvalid = v;
    end

    always @(posedge clk) begin
        if (rst) bt <= 4'b0;
        else if (auto_en) bt <= bt ^ (s_tready & v);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        v        = 4'b0;
        l        = 4'b0;
        auto_en  = 1'b0;
        m_tready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [3:0] exp_g [13] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                               4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000,
                               4'b0001};

    initial begin
        for (int i = 0; i < 4; i++) begin
            d[i] = 8'h00;
            u[i] = 12'd0;
        end
        do_reset();

        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_tready", 64'(s_tready), 64'h0);
        chk("rst_mvalid", 64'(m_tvalid), 64'h0);
        chk("rst_mlast", 64'(m_tlast), 64'h0);
        chk("rst_tuser", 64'(m_tuser), 64'h0);
        chk("rst_lenerr", 64'(len_err), 64'h0);

        // Single 4-beat packet from source 0.
        v[0] = 1'b1; u[0] = 12'd4; d[0] = 8'hA0; m_tready = 1'b1;
        @(negedge clk);
        chk("t1_grant", 64'(grant), 64'h1);
        chk("t1_tready", 64'(s_tready), 64'h1);
        chk("t1_data0", 64'(m_tdata), 64'hA0);
        chk("t1_tuser0", 64'(m_tuser), 64'd4);
        for (int b = 1; b <= 3; b++) begin
            @(negedge clk);
            d[0] = 8'hA0 + 8'(b);
            l[0] = (b == 3);
            #1;
            chk("t1_data", 64'(m_tdata), 64'(8'hA0 + 8'(b)));
            chk("t1_last", 64'(m_tlast), 64'(b == 3));
            chk("t1_tuser", 64'(m_tuser), 64'd4);
        end
        @(negedge clk);
        chk("t1_grant_end", 64'(grant), 64'h0);
        chk("t1_lenerr", 64'(len_err), 64'h0);
        v[0] = 1'b0; l[0] = 1'b0;

        // All sources valid continuously, 2-beat packets: strict rotation with idle bubbles.
        do_reset();
        for (int i = 0; i < 4; i++) u[i] = 12'd2;
        v = 4'hF; auto_en = 1'b1; m_tready = 1'b1;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            chk("rr_grant", 64'(grant), 64'(exp_g[k]));
            chk("rr_mvalid", 64'(m_tvalid), 64'(exp_g[k] != 4'b0));
        end
        chk("rr_lenerr", 64'(len_err), 64'h0);

        // Source 2 granted while packet_gen stalls the first beat.
        do_reset();
        v[2] = 1'b1; d[2] = 8'hC0; u[2] = 12'd2; l[2] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("stall_grant", 64'(grant), 64'h4);
            chk("stall_tready", 64'(s_tready), 64'h0);
        end
        chk("stall_data", 64'(m_tdata), 64'hC0);
        m_tready = 1'b1;
        #1;
        chk("stall_tready_on", 64'(s_tready), 64'h4);
        @(negedge clk);
        d[2] = 8'hC1; l[2] = 1'b1;
        #1;
        chk("stall_data1", 64'(m_tdata), 64'hC1);
        chk("stall_last", 64'(m_tlast), 64'h1);
        @(negedge clk);
        chk("stall_grant_end", 64'(grant), 64'h0);
        chk("stall_lenerr", 64'(len_err), 64'h0);
        v[2] = 1'b0; l[2] = 1'b0;

        // Source 1 announces 3 beats but sends 5.
        do_reset();
        v[1] = 1'b1; u[1] = 12'd3; d[1] = 8'h10; l[1] = 1'b0; m_tready = 1'b1;
        @(negedge clk);
        chk("len_grant", 64'(grant), 64'h2);
        chk("len_data0", 64'(m_tdata), 64'h10);
        for (int b = 1; b <= 4; b++) begin
            @(negedge clk);
            d[1] = 8'h10 + 8'(b);
            l[1] = (b == 4);
            #1;
            chk("len_data", 64'(m_tdata), 64'(8'h10 + 8'(b)));
            chk("len_noerr", 64'(len_err), 64'h0);
        end
        @(negedge clk);
        chk("len_err_pulse", 64'(len_err), 64'h1);
        chk("len_grant_end", 64'(grant), 64'h0);
        v[1] = 1'b0; l[1] = 1'b0;
        @(negedge clk);
        chk("len_err_clear", 64'(len_err), 64'h0);
        v[0] = 1'b1; v[2] = 1'b1; d[0] = 8'h01; d[2] = 8'h02; u[0] = 12'd1; u[2] = 12'd1;
        @(negedge clk);
        chk("len_ptr_next", 64'(grant), 64'h4);

        // Reset asserted on beat 2 of a 6-beat packet.
        do_reset();
        v[0] = 1'b1; d[0] = 8'h50; u[0] = 12'd6; l[0] = 1'b0; m_tready = 1'b1;
        @(negedge clk);
        chk("mr_grant", 64'(grant), 64'h1);
        @(negedge clk);
        d[0] = 8'h51;
        @(negedge clk);
        d[0] = 8'h52;
        rst  = 1'b1;
        @(negedge clk);
        chk("mr_grant_rst", 64'(grant), 64'h0);
        chk("mr_tready_rst", 64'(s_tready), 64'h0);
        chk("mr_mvalid_rst", 64'(m_tvalid), 64'h0);
        chk("mr_mlast_rst", 64'(m_tlast), 64'h0);
        chk("mr_tuser_rst", 64'(m_tuser), 64'h0);
        chk("mr_lenerr_rst", 64'(len_err), 64'h0);
        rst = 1'b0; v[1] = 1'b1; u[1] = 12'd1; d[0] = 8'h50;
        @(negedge clk);
        chk("mr_first_win", 64'(grant), 64'h1);

`ifdef TX_ARB_STATS_EN
        // Three single-beat packets from source 3.
        do_reset();
        v[3] = 1'b1; l[3] = 1'b1; u[3] = 12'd1; d[3] = 8'h33; m_tready = 1'b1;
        repeat (6) @(negedge clk);
        v[3] = 1'b0; l[3] = 1'b0;
        @(negedge clk);
        chk("stats_pkt", pkt_count, {16'd3, 48'd0});
        chk("stats_err", 64'(err_count), 64'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
